// File: rtl/pulse_sort.sv
// pulse_sort: classifies each pwm_on window as OPEN/NORMAL/ARC/SHORT; define PULSE_SORT_STAT_EN for statistics counters
module pulse_sort #(
  parameter logic [11:0] V_BREAK = 12'd350,
  parameter logic [11:0] I_BREAK = 12'd2600,
  parameter logic [11:0] V_SHORT = 12'd100,
  parameter int TD_W = 10,
  parameter logic [TD_W-1:0] T_SHORT_MAX = 10'd5,
  parameter logic [TD_W-1:0] T_ARC_MAX = 10'd25,
  parameter logic [3:0] SHORT_N = 4'd3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_signal,
  input  logic            pwm_on,
  input  logic [11:0]     ad_ch1,
  input  logic [11:0]     ad_ch2,
  input  logic            stat_clr,
  output logic [1:0]      pulse_type,
  output logic            type_valid,
  output logic [TD_W-1:0] ign_delay,
  output logic            pro1_short_flag,
  output logic [15:0]     cnt_open,
  output logic [15:0]     cnt_normal,
  output logic [15:0]     cnt_arc,
  output logic [15:0]     cnt_short
);
  typedef enum logic [1:0] {IDLE, DELAY, BURN, DONE} state_t;
  state_t state, state_nxt;
  logic [TD_W-1:0] td_cnt, td_inc, d_cls;
  logic [11:0] v_bd, v_cls;
  logic [3:0] short_run, sr_nxt;
  logic [1:0] cls;
  logic pwm_on_d, armed, rise, bd, in_delay, latch;
  // armed blocks a pulse that is already high when reset releases from looking like a fresh rise
  assign rise = pwm_on & ~pwm_on_d & armed;
  assign bd = (ad_ch1 < V_BREAK) && (ad_ch2 >= I_BREAK);
  assign in_delay = state == DELAY;
  assign td_inc = &td_cnt ? td_cnt : td_cnt + 1'b1;
  assign latch = start_signal && in_delay && (bd || !pwm_on);
  // a breakdown in the falling cycle is classified from the live inputs, otherwise from the latched ones
  assign d_cls = in_delay ? td_inc : ign_delay;
  assign v_cls = in_delay ? ad_ch1 : v_bd;
  assign cls = (in_delay && !bd) ? 2'd0 :
               (d_cls < T_SHORT_MAX && v_cls < V_SHORT) ? 2'd3 :
               (d_cls < T_ARC_MAX) ? 2'd2 : 2'd1;
  assign sr_nxt = pulse_type == 2'd3 ? short_run + {3'd0, ~&short_run} :
                  pulse_type == 2'd2 ? short_run : 4'd0;
  // next-state: dropping start_signal overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = rise ? DELAY : IDLE;
      DELAY:   state_nxt = (bd || !pwm_on) ? (pwm_on ? BURN : DONE) : DELAY;
      BURN:    state_nxt = pwm_on ? BURN : DONE;
      default: state_nxt = IDLE;
    endcase
    if (!start_signal) state_nxt = IDLE;
  end
  // state, delay measurement, classification result and repeated-short tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      td_cnt <= '0;
      v_bd <= '0;
      short_run <= '0;
      pwm_on_d <= 1'b0;
      armed <= 1'b0;
      ign_delay <= '0;
      pulse_type <= '0;
      type_valid <= 1'b0;
      pro1_short_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      pwm_on_d <= pwm_on;
      armed <= armed | ~pwm_on;
      td_cnt <= in_delay ? td_inc : '0;
      if (latch) ign_delay <= td_inc;
      if (latch && bd) v_bd <= ad_ch1;
      if (state_nxt == DONE) pulse_type <= cls;
      type_valid <= state_nxt == DONE;
      short_run <= !start_signal ? 4'd0 : state == DONE ? sr_nxt : short_run;
      pro1_short_flag <= start_signal && ((state == DONE ? sr_nxt : short_run) >= SHORT_N);
    end
  end
`ifdef PULSE_SORT_STAT_EN
  logic [15:0] cnt [4];
  // saturating per-type counters; stat_clr beats a coinciding increment
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) for (int i = 0; i < 4; i++) cnt[i] <= '0;
    else if (type_valid && ~&cnt[pulse_type]) cnt[pulse_type] <= cnt[pulse_type] + 1'b1;
  end
  assign cnt_open = cnt[0];
  assign cnt_normal = cnt[1];
  assign cnt_arc = cnt[2];
  assign cnt_short = cnt[3];
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign cnt_open = '0;
  assign cnt_normal = '0;
  assign cnt_arc = '0;
  assign cnt_short = '0;
`endif
endmodule
